// File: rtl/homing_controller.sv
// Homing sequencer for X/Y/Z steppers: fast approach, back-off, slow re-approach, load home.
// Define HOMING_TIMEOUT_EN to fault an approach phase after MAX_STEPS steps without an endstop hit.
module homing_controller #(
    parameter int FAST_PERIOD   = 2500,
    parameter int SLOW_PERIOD   = 10000,
    parameter int STEP_HIGH     = 50,
    parameter int BACKOFF_STEPS = 200,
    parameter int MAX_STEPS     = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] axis_mask,
    input  logic       endstop_x,
    input  logic       endstop_y,
    input  logic       endstop_z,
    output logic       stepper_x_enable,
    output logic       stepper_y_enable,
    output logic       stepper_z_enable,
    output logic       stepper_x_step,
    output logic       stepper_y_step,
    output logic       stepper_z_step,
    output logic       stepper_x_direction,
    output logic       stepper_y_direction,
    output logic       stepper_z_direction,
    output logic       stepper_x_set_new_coordinates,
    output logic       stepper_y_set_new_coordinates,
    output logic       stepper_z_set_new_coordinates,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] homed
);
    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_FAST, S_BACKOFF, S_SLOW, S_SET, S_ERROR} state_t;

    localparam int PMAX = (SLOW_PERIOD > FAST_PERIOD) ? SLOW_PERIOD : FAST_PERIOD;
    localparam int PW   = $clog2(PMAX);
    localparam int BW   = $clog2(BACKOFF_STEPS + 1);

    state_t        state_q, state_d;
    logic [2:0]    es_meta_q, es_sync_q;
    logic [2:0]    pend_q, pend_d, homed_q, homed_d, en_n_q, en_n_d;
    logic [1:0]    axis_q, axis_d;
    logic          dir_q, dir_d, step_q, step_d, set_q, set_d;
    logic          set_cnt_q, set_cnt_d, done_q, done_d, error_q, error_d;
    logic [PW-1:0] per_q, per_d, per_last;
    logic [BW-1:0] bk_q, bk_d;
    logic [2:0]    lowest, axis_oh;
    logic          es_act, moving, boundary, entry, tmo_hit;

    assign lowest   = pend_q & (~pend_q + 3'd1);
    assign axis_oh  = 3'b001 << axis_q;
    assign es_act   = es_sync_q[axis_q];
    assign moving   = (state_q == S_FAST) || (state_q == S_BACKOFF) || (state_q == S_SLOW);
    assign per_last = (state_q == S_FAST) ? PW'(FAST_PERIOD - 1) : PW'(SLOW_PERIOD - 1);
    assign boundary = (per_q == per_last);
    // Counter at zero with the step low only happens in the first cycle of a phase.
    assign entry    = (per_q == '0) && !step_q;

`ifdef HOMING_TIMEOUT_EN
    localparam int TW = $clog2(MAX_STEPS + 1);
    logic [TW-1:0] tmo_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                tmo_q <= '0;
        else if (state_d != state_q)               tmo_q <= '0;
        else if ((state_q == S_FAST || state_q == S_SLOW) && step_d && !step_q)
                                                   tmo_q <= tmo_q + 1'b1;
    end
    assign tmo_hit = (tmo_q == TW'(MAX_STEPS));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            es_meta_q <= '0;
            es_sync_q <= '0;
            pend_q    <= '0;
            homed_q   <= '0;
            en_n_q    <= 3'b111;
            axis_q    <= '0;
            dir_q     <= 1'b0;
            step_q    <= 1'b0;
            set_q     <= 1'b0;
            set_cnt_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            per_q     <= '0;
            bk_q      <= '0;
        end else begin
            state_q   <= state_d;
            es_meta_q <= {endstop_z, endstop_y, endstop_x};
            es_sync_q <= es_meta_q;
            pend_q    <= pend_d;
            homed_q   <= homed_d;
            en_n_q    <= en_n_d;
            axis_q    <= axis_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            set_q     <= set_d;
            set_cnt_q <= set_cnt_d;
            done_q    <= done_d;
            error_q   <= error_d;
            per_q     <= per_d;
            bk_q      <= bk_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        homed_d   = homed_q;
        en_n_d    = en_n_q;
        axis_d    = axis_q;
        dir_d     = dir_q;
        step_d    = step_q;
        set_d     = set_q;
        set_cnt_d = set_cnt_q;
        done_d    = 1'b0;
        error_d   = error_q;
        per_d     = per_q;
        bk_d      = bk_q;

        if (moving) begin
            per_d = boundary ? '0 : per_q + 1'b1;
            if (step_q && per_q == PW'(STEP_HIGH - 1)) step_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: if (start) begin
                pend_d  = axis_mask;
                homed_d = homed_q & ~axis_mask;
                error_d = 1'b0;
                state_d = S_SELECT;
            end
            S_SELECT: if (pend_q == '0) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                axis_d  = lowest[0] ? 2'd0 : (lowest[1] ? 2'd1 : 2'd2);
                en_n_d  = en_n_q & ~lowest;
                dir_d   = 1'b1;
                per_d   = '0;
                state_d = S_FAST;
            end
            S_FAST, S_SLOW: if ((entry || boundary) && es_act) begin
                per_d = '0;
                if (state_q == S_FAST) begin
                    dir_d   = 1'b0;
                    bk_d    = '0;
                    state_d = S_BACKOFF;
                end else begin
                    set_d     = 1'b1;
                    set_cnt_d = 1'b0;
                    state_d   = S_SET;
                end
            end else if (boundary) begin
                if (tmo_hit) begin
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    step_d = 1'b1;
                end
            end
            S_BACKOFF: if (boundary) begin
                if (bk_q == BW'(BACKOFF_STEPS)) begin
                    if (es_act) begin
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        dir_d   = 1'b1;
                        per_d   = '0;
                        state_d = S_SLOW;
                    end
                end else begin
                    step_d = 1'b1;
                    bk_d   = bk_q + 1'b1;
                end
            end
            S_SET: begin
                set_cnt_d = 1'b1;
                if (set_cnt_q) begin
                    set_d   = 1'b0;
                    homed_d = homed_q | axis_oh;
                    pend_d  = pend_q & ~axis_oh;
                    state_d = S_SELECT;
                end
            end
            S_ERROR: begin
                step_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything else, including a start in the same cycle.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            step_d  = 1'b0;
            set_d   = 1'b0;
            done_d  = 1'b0;
            error_d = error_q;
            homed_d = homed_q;
        end else if (abort) begin
            state_d = S_IDLE;
            pend_d  = pend_q;
            homed_d = homed_q;
            error_d = error_q;
        end
    end

    assign stepper_x_enable = en_n_q[0];
    assign stepper_y_enable = en_n_q[1];
    assign stepper_z_enable = en_n_q[2];
    assign stepper_x_step   = step_q & axis_oh[0];
    assign stepper_y_step   = step_q & axis_oh[1];
    assign stepper_z_step   = step_q & axis_oh[2];
    assign stepper_x_direction = dir_q & axis_oh[0];
    assign stepper_y_direction = dir_q & axis_oh[1];
    assign stepper_z_direction = dir_q & axis_oh[2];
    assign stepper_x_set_new_coordinates = set_q & axis_oh[0];
    assign stepper_y_set_new_coordinates = set_q & axis_oh[1];
    assign stepper_z_set_new_coordinates = set_q & axis_oh[2];
    assign busy  = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign done  = done_q;
    assign error = error_q;
    assign homed = homed_q;
endmodule
